axis_iic_arbiter: RTL
=====================

AXIS_IIC_ARBITER -- requirements
Module: axis_iic_arbiter

Interface
REQ-001 Parameters (name, default, meaning): N_PORTS, 4, number of requester ports; N_BYTES, 32, AXIS data bytes per beat; TIMEOUT_CYCLES, 1000000, maximum clk cycles to wait for a read response.
REQ-002 Port clk, input, 1: single clock for all logic.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Ports s_axis_tdata/tkeep/tuser/tvalid/tlast, inputs, N_PORTS x (N_BYTES*8 / N_BYTES / 8 / 1 / 1), flattened with port i at slice i: requester command packets; tuser[0]=1 marks a read.
REQ-005 Port s_axis_tready, output, N_PORTS: per-requester ready.
REQ-006 Ports m_axis_tdata/tkeep/tuser/tvalid/tlast, outputs, flattened as in REQ-004: per-requester response packets.
REQ-007 Port m_axis_tready, input, N_PORTS: per-requester response ready.
REQ-008 Ports br_m_axis_tdata/tkeep/tuser/tvalid/tlast, outputs, and br_m_axis_tready, input: command stream to the I2C bridge.
REQ-009 Ports br_s_axis_tdata/tkeep/tuser/tvalid/tlast, inputs, and br_s_axis_tready, output: response stream from the I2C bridge.
REQ-010 Port grant_id, output, $clog2(N_PORTS): currently granted port; port busy, output, 1: high outside IDLE_ST.
REQ-011 Port timeout_err, output, N_PORTS: one-cycle pulse on the port whose read timed out.

Function
REQ-012 FSM states: IDLE_ST, FWD_ST, RESP_ST, FLUSH_ST.
REQ-013 IDLE_ST: when any s_axis_tvalid is high, the next state is FWD_ST and the grant is registered; the winner is the first requester with tvalid high, searched from rr_ptr upward with wrap-around.
REQ-014 On grant, rr_ptr is loaded with (winner+1) mod N_PORTS; with all tvalid low, rr_ptr holds.
REQ-015 The read flag is latched from tuser[0] of the granted port's first beat.
REQ-016 FWD_ST: br_m_axis_* is a combinational passthrough of the granted s_axis_*; the granted tready equals br_m_axis_tready; every other s_axis_tready is 0.
REQ-017 FWD_ST exit on the tlast handshake: a read goes to RESP_ST with the timeout counter cleared; a write goes to IDLE_ST.
REQ-018 A packet is never interrupted; the grant changes only in IDLE_ST.
REQ-019 RESP_ST: br_s_axis_* is passed through to the granted m_axis_*; br_s_axis_tready equals the granted m_axis_tready; every other m_axis_tvalid is 0.
REQ-020 RESP_ST exit: the br_s_axis tlast handshake returns the FSM to IDLE_ST.
REQ-021 Timeout counter: increments each RESP_ST cycle in which no response beat is accepted; it is cleared on any accepted beat.
REQ-022 When the timeout counter reaches TIMEOUT_CYCLES-1: pulse timeout_err[grant_id] and go to IDLE_ST.
REQ-023 FLUSH_ST: entered from IDLE_ST if br_s_axis_tvalid is high while no read is outstanding; br_s_axis_tready is held at 1 until the tlast handshake, then the FSM returns to IDLE_ST; stray data is dropped.
REQ-024 FLUSH_ST has priority over a new grant when both are pending in the same cycle.
REQ-025 Single-beat packets (tvalid and tlast in the same cycle) are legal in both directions.
REQ-026 Back-to-back packets: at most one idle cycle between the tlast handshake and the next grant.

Reset
REQ-027 Reset state: FSM in IDLE_ST; rr_ptr, grant_id, the read flag and the timeout counter are 0.
REQ-028 Reset values: all s_axis_tready, m_axis_tvalid, br_m_axis_tvalid, br_s_axis_tready, busy and timeout_err are 0.
REQ-029 Reset asserted mid-packet returns the FSM to IDLE_ST on the next edge; the partial packet is abandoned and no flush is performed.

Structure
REQ-030 Package axis_iic_arbiter_pkg holds the state enum type and the timeout counter width function.
REQ-031 Sub-module rr_arbiter (N_PORTS): combinational round-robin search taking a request vector and rr_ptr, returning the winner index and a valid flag.

Verification
REQ-031 (sic) numbering continues below:
REQ-032 Round robin: all 4 ports raise single-beat writes at once -> grants in order 0,1,2,3,0; s_axis_tready is never high on two ports at once.
REQ-033 Read: port 2 sends 1 beat with tuser=8'hA1; bridge returns 2 beats -> both beats appear on port 2 only, tlast on the 2nd beat, then busy falls.
REQ-034 Timeout: TIMEOUT_CYCLES=16; port 1 reads and the bridge is silent -> timeout_err[1] pulses 16 cycles after entering RESP_ST; port 0 is granted next.
REQ-035 Backpressure: br_m_axis_tready toggles every cycle during a 3-beat write from port 3 -> data arrives at the bridge intact and in order.
REQ-036 Reset: reset asserted on beat 2 of 3 -> the next cycle shows all outputs at their reset values and rr_ptr=0.
REQ-037 Stray response: bridge sends 1 beat while idle and port 0 is requesting -> FLUSH_ST is taken first, m_axis_tvalid stays 0, then port 0 is granted.

Source files
------------

// File: rtl/axis_iic_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream I2C bridge arbiter.
package axis_iic_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE_ST,
        FWD_ST,
        RESP_ST,
        FLUSH_ST
    } arb_state_t;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]         req,
    input  logic [$clog2(N_PORTS)-1:0] rr_ptr,
    output logic [$clog2(N_PORTS)-1:0] winner,
    output logic                       valid
);

    localparam int PW = $clog2(N_PORTS);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = PW'((int'(rr_ptr) + i) % N_PORTS);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_iic_arbiter.sv
// Shares one I2C bridge command/response stream pair among N_PORTS AXI-Stream requesters.
module axis_iic_arbiter
    import axis_iic_arbiter_pkg::*;
#(
    parameter int N_PORTS        = 4,
    parameter int N_BYTES        = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [N_PORTS*N_BYTES*8-1:0] s_axis_tdata,
    input  logic [N_PORTS*N_BYTES-1:0]   s_axis_tkeep,
    input  logic [N_PORTS*8-1:0]         s_axis_tuser,
    input  logic [N_PORTS-1:0]           s_axis_tvalid,
    input  logic [N_PORTS-1:0]           s_axis_tlast,
    output logic [N_PORTS-1:0]           s_axis_tready,

    output logic [N_PORTS*N_BYTES*8-1:0] m_axis_tdata,
    output logic [N_PORTS*N_BYTES-1:0]   m_axis_tkeep,
    output logic [N_PORTS*8-1:0]         m_axis_tuser,
    output logic [N_PORTS-1:0]           m_axis_tvalid,
    output logic [N_PORTS-1:0]           m_axis_tlast,
    input  logic [N_PORTS-1:0]           m_axis_tready,

    output logic [N_BYTES*8-1:0]         br_m_axis_tdata,
    output logic [N_BYTES-1:0]           br_m_axis_tkeep,
    output logic [7:0]                   br_m_axis_tuser,
    output logic                         br_m_axis_tvalid,
    output logic                         br_m_axis_tlast,
    input  logic                         br_m_axis_tready,

    input  logic [N_BYTES*8-1:0]         br_s_axis_tdata,
    input  logic [N_BYTES-1:0]           br_s_axis_tkeep,
    input  logic [7:0]                   br_s_axis_tuser,
    input  logic                         br_s_axis_tvalid,
    input  logic                         br_s_axis_tlast,
    output logic                         br_s_axis_tready,

    output logic [$clog2(N_PORTS)-1:0]   grant_id,
    output logic                         busy,
    output logic [N_PORTS-1:0]           timeout_err
);

    localparam int DW = N_BYTES * 8;
    localparam int PW = $clog2(N_PORTS);
    localparam int TW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

    arb_state_t         state, state_nxt;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt, grant_nxt, winner;
    logic               win_valid;
    logic               read_flag, read_flag_nxt;
    logic [TW-1:0]      tmo_cnt, tmo_cnt_nxt;
    logic [N_PORTS-1:0] timeout_nxt;

    logic [DW-1:0]      sel_tdata;
    logic [N_BYTES-1:0] sel_tkeep;
    logic [7:0]         sel_tuser;
    logic               sel_tvalid, sel_tlast, sel_m_tready, win_read;

    rr_arbiter #(.N_PORTS(N_PORTS)) u_rr_arbiter (
        .req    (s_axis_tvalid),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    // Response data is broadcast; only the granted tvalid is ever raised.
    assign m_axis_tdata = {N_PORTS{br_s_axis_tdata}};
    assign m_axis_tkeep = {N_PORTS{br_s_axis_tkeep}};
    assign m_axis_tuser = {N_PORTS{br_s_axis_tuser}};
    assign m_axis_tlast = {N_PORTS{br_s_axis_tlast}};
    assign busy         = (state != IDLE_ST);

    always_comb begin
        sel_tdata    = '0;
        sel_tkeep    = '0;
        sel_tuser    = '0;
        sel_tvalid   = 1'b0;
        sel_tlast    = 1'b0;
        sel_m_tready = 1'b0;
        win_read     = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_id == PW'(i)) begin
                sel_tdata    = s_axis_tdata[i*DW +: DW];
                sel_tkeep    = s_axis_tkeep[i*N_BYTES +: N_BYTES];
                sel_tuser    = s_axis_tuser[i*8 +: 8];
                sel_tvalid   = s_axis_tvalid[i];
                sel_tlast    = s_axis_tlast[i];
                sel_m_tready = m_axis_tready[i];
            end
            if (winner == PW'(i)) begin
                win_read = s_axis_tuser[i*8];
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant_id;
        rr_ptr_nxt       = rr_ptr;
        read_flag_nxt    = read_flag;
        tmo_cnt_nxt      = tmo_cnt;
        timeout_nxt      = '0;
        s_axis_tready    = '0;
        m_axis_tvalid    = '0;
        br_m_axis_tvalid = 1'b0;
        br_s_axis_tready = 1'b0;
        br_m_axis_tdata  = sel_tdata;
        br_m_axis_tkeep  = sel_tkeep;
        br_m_axis_tuser  = sel_tuser;
        br_m_axis_tlast  = sel_tlast;

        case (state)
            IDLE_ST: begin
                // A stray bridge response must be drained before any new command goes out.
                if (br_s_axis_tvalid) begin
                    state_nxt = FLUSH_ST;
                end else if (win_valid) begin
                    state_nxt     = FWD_ST;
                    grant_nxt     = winner;
                    rr_ptr_nxt    = (winner == LAST_PORT) ? '0 : winner + PW'(1);
                    read_flag_nxt = win_read;
                end
            end

            FWD_ST: begin
                br_m_axis_tvalid = sel_tvalid;
                for (int i = 0; i < N_PORTS; i++) begin
                    s_axis_tready[i] = (grant_id == PW'(i)) && br_m_axis_tready;
                end
                if (sel_tvalid && br_m_axis_tready && sel_tlast) begin
                    if (read_flag) begin
                        state_nxt   = RESP_ST;
                        tmo_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE_ST;
                    end
                end
            end

            RESP_ST: begin
                br_s_axis_tready = sel_m_tready;
                for (int i = 0; i < N_PORTS; i++) begin
                    m_axis_tvalid[i] = (grant_id == PW'(i)) && br_s_axis_tvalid;
                end
                if (br_s_axis_tvalid && sel_m_tready) begin
                    tmo_cnt_nxt = '0;
                    if (br_s_axis_tlast) begin
                        state_nxt = IDLE_ST;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE_ST;
                    for (int i = 0; i < N_PORTS; i++) begin
                        timeout_nxt[i] = (grant_id == PW'(i));
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TW'(1);
                end
            end

            FLUSH_ST: begin
                br_s_axis_tready = 1'b1;
                if (br_s_axis_tvalid && br_s_axis_tlast) begin
                    state_nxt = IDLE_ST;
                end
            end

            default: state_nxt = IDLE_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE_ST;
            grant_id    <= '0;
            rr_ptr      <= '0;
            read_flag   <= 1'b0;
            tmo_cnt     <= '0;
            timeout_err <= '0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            read_flag   <= read_flag_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule
